ras: RTL and testbench



---
 rtl/ras.sv | 80 ++++++++
 tb/tb_ras.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ras.sv
// Return address stack: circular buffer with saturating occupancy and checkpoint recovery.
// Optional RAS_RECOVER_TOP_EN: recovery also rewrites the checkpointed top entry.
module ras #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [29:0]      push_pc_i,
   input  logic             pop_i,
   input  logic             recover_i,
   input  logic [PTR_W-1:0] recover_ptr_i,
   input  logic [PTR_W:0]   recover_cnt_i,
   input  logic [29:0]      recover_top_i,
   output logic [29:0]      top_o,
   output logic             valid_o,
   output logic [PTR_W-1:0] ptr_o,
   output logic [PTR_W:0]   cnt_o
);

   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [29:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [29:0]      wr_data;

   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_addr = ptr_q;
      wr_data = push_pc_i;
      if (recover_i) begin
         ptr_d = recover_ptr_i;
         cnt_d = (recover_cnt_i > FULL) ? FULL : recover_cnt_i;
`ifdef RAS_RECOVER_TOP_EN
         wr_en   = 1'b1;
         wr_addr = recover_ptr_i;
         wr_data = recover_top_i;
`endif
      end else if (push_i && pop_i && cnt_q != '0) begin
         // tail call: replace the top in place
         wr_en = 1'b1;
      end else if (push_i) begin
         wr_en   = 1'b1;
         wr_addr = ptr_q + 1'b1;
         ptr_d   = ptr_q + 1'b1;
         if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
      end else if (pop_i && cnt_q != '0) begin
         ptr_d = ptr_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

`ifndef RAS_RECOVER_TOP_EN
   logic unused_top;
   assign unused_top = ^recover_top_i;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         if (wr_en) mem_q[wr_addr] <= wr_data;
      end
   end

   assign top_o   = (cnt_q == '0) ? '0 : mem_q[ptr_q];
   assign valid_o = (cnt_q != '0);
   assign ptr_o   = ptr_q;
   assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_ras.sv
// Scoreboard bench for ras at DEPTH=4: stimulus queues expected state, a negedge monitor compares.
module tb_ras;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk = 1'b0;
   logic             rst, push_i, pop_i, recover_i;
   logic [29:0]      push_pc_i, recover_top_i;
   logic [PTR_W-1:0] recover_ptr_i;
   logic [PTR_W:0]   recover_cnt_i;
   logic [29:0]      top_o;
   logic             valid_o;
   logic [PTR_W-1:0] ptr_o;
   logic [PTR_W:0]   cnt_o;

   ras #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push_i(push_i), .push_pc_i(push_pc_i), .pop_i(pop_i),
      .recover_i(recover_i), .recover_ptr_i(recover_ptr_i), .recover_cnt_i(recover_cnt_i),
      .recover_top_i(recover_top_i), .top_o(top_o), .valid_o(valid_o), .ptr_o(ptr_o),
      .cnt_o(cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            name;
      logic [29:0]      top;
      logic             vld;
      logic [PTR_W-1:0] ptr;
      logic [PTR_W:0]   cnt;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (top_o !== e.top || valid_o !== e.vld || ptr_o !== e.ptr || cnt_o !== e.cnt) begin
            errors++;
            $display("FAIL %s: got top=%h valid=%b ptr=%0d cnt=%0d, want top=%h valid=%b ptr=%0d cnt=%0d",
                     e.name, top_o, valid_o, ptr_o, cnt_o, e.top, e.vld, e.ptr, e.cnt);
         end
      end
   end

   task automatic step(input logic r, input logic pu, input logic po, input logic rc,
                       input logic [29:0] pc, input logic [PTR_W-1:0] rp,
                       input logic [PTR_W:0] rcn, input logic [29:0] rt);
      rst = r; push_i = pu; pop_i = po; recover_i = rc;
      push_pc_i = pc; recover_ptr_i = rp; recover_cnt_i = rcn; recover_top_i = rt;
      @(posedge clk);
      #1;
      rst = 1'b0; push_i = 1'b0; pop_i = 1'b0; recover_i = 1'b0;
   endtask

   task automatic expect_st(input string n, input logic [29:0] t, input logic v,
                            input logic [PTR_W-1:0] p, input logic [PTR_W:0] c);
      exp_t e;
      e.name = n; e.top = t; e.vld = v; e.ptr = p; e.cnt = c;
      q.push_back(e);
   endtask

   task automatic do_reset();  step(1, 0, 0, 0, 30'h0, 2'd0, 3'd0, 30'h0); endtask
   task automatic do_push(input logic [29:0] pc); step(0, 1, 0, 0, pc, 2'd0, 3'd0, 30'h0); endtask
   task automatic do_pop();    step(0, 0, 1, 0, 30'h0, 2'd0, 3'd0, 30'h0); endtask

   initial begin
      // basic push/pop and tail-call replace
      do_reset();                                expect_st("reset", 30'h0, 0, 0, 0);
      do_push(30'h100);                          expect_st("push1", 30'h100, 1, 1, 1);
      do_push(30'h200);
      do_push(30'h300);                          expect_st("push3", 30'h300, 1, 3, 3);
      do_pop();                                  expect_st("pop1", 30'h200, 1, 2, 2);
      step(0, 1, 1, 0, 30'h500, 2'd0, 3'd0, 30'h0);
      expect_st("tailcall", 30'h500, 1, 2, 2);
      step(0, 0, 0, 0, 30'h0, 2'd0, 3'd0, 30'h0);
      expect_st("idle_hold", 30'h500, 1, 2, 2);

      // empty behaviour
      do_reset();                                expect_st("reset2", 30'h0, 0, 0, 0);
      do_pop();                                  expect_st("pop_empty", 30'h0, 0, 0, 0);
      do_push(30'h40);                           expect_st("push_after_empty", 30'h40, 1, 1, 1);
      do_reset();
      step(0, 1, 1, 0, 30'h66, 2'd0, 3'd0, 30'h0);
      expect_st("pushpop_empty", 30'h66, 1, 1, 1);

      // overflow wrap then drain
      do_reset();
      for (int i = 1; i <= 5; i++) do_push(30'(i));
      expect_st("full_wrap", 30'h5, 1, 1, 4);
      do_pop();                                  expect_st("drain1", 30'h4, 1, 0, 3);
      do_pop();                                  expect_st("drain2", 30'h3, 1, 3, 2);
      do_pop();                                  expect_st("drain3", 30'h2, 1, 2, 1);
      do_pop();                                  expect_st("drain4", 30'h0, 0, 1, 0);

      // recovery: mem0=40 mem1=10 mem2=20 mem3=30 after four pushes
      do_reset();
      do_push(30'h10); do_push(30'h20); do_push(30'h30); do_push(30'h40);
      expect_st("fill4", 30'h40, 1, 0, 4);
      step(0, 0, 0, 1, 30'h0, 2'd1, 3'd2, 30'h10);
      expect_st("recover_ckpt", 30'h10, 1, 1, 2);
      do_push(30'h9);                            expect_st("wp_push", 30'h9, 1, 2, 3);
      do_pop();                                  expect_st("wp_pop1", 30'h10, 1, 1, 2);
      do_pop();                                  expect_st("wp_pop2", 30'h40, 1, 0, 1);
      step(0, 1, 0, 1, 30'h99, 2'd1, 3'd2, 30'h10);
      expect_st("recover_beats_push", 30'h10, 1, 1, 2);

      // wrong-path clobber of top entry
      do_pop();                                  expect_st("clobber_pop", 30'h40, 1, 0, 1);
      do_push(30'h888);                          expect_st("clobber_push", 30'h888, 1, 1, 2);
      step(0, 0, 0, 1, 30'h0, 2'd1, 3'd2, 30'h777);
`ifdef RAS_RECOVER_TOP_EN
      expect_st("recover_top", 30'h777, 1, 1, 2);
`else
      expect_st("recover_top", 30'h888, 1, 1, 2);
`endif
      step(0, 0, 0, 1, 30'h0, 2'd2, 3'd7, 30'h9);
      expect_st("recover_cnt_sat", 30'h9, 1, 2, 4);

      // reset wins over everything
      step(1, 1, 1, 1, 30'h123, 2'd3, 3'd3, 30'h55);
      expect_st("reset_priority", 30'h0, 0, 0, 0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
